// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared RISC-V register-file parameters and types.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : riscv_pkg

// File: rtl/regfile_2r1w_sb_if.sv
// Decode/writeback <-> register file signal bundle.
interface regfile_2r1w_sb_if;

  // Decode-side read ports
  riscv_pkg::reg_addr_t       Rd_Addr_A;
  logic                       Rd_Use_A;
  logic [riscv_pkg::XLEN-1:0] Rd_Data_A;
  riscv_pkg::reg_addr_t       Rd_Addr_B;
  logic                       Rd_Use_B;
  logic [riscv_pkg::XLEN-1:0] Rd_Data_B;

  // Writeback-side write port
  logic                       Wr_En;
  riscv_pkg::reg_addr_t       Wr_Addr;
  logic [riscv_pkg::XLEN-1:0] Wr_Data;

  // Load scoreboard
  logic                       Busy_Set;
  riscv_pkg::reg_addr_t       Busy_Addr;
  logic                       Stall;
  logic [riscv_pkg::NREG-1:0] Busy_Vec;

  // Pipeline side: drives addresses, writes and busy requests
  modport master (
    output Rd_Addr_A, Rd_Use_A, Rd_Addr_B, Rd_Use_B,
    output Wr_En, Wr_Addr, Wr_Data, Busy_Set, Busy_Addr,
    input  Rd_Data_A, Rd_Data_B, Stall, Busy_Vec
  );

  // Register file side
  modport slave (
    input  Rd_Addr_A, Rd_Use_A, Rd_Addr_B, Rd_Use_B,
    input  Wr_En, Wr_Addr, Wr_Data, Busy_Set, Busy_Addr,
    output Rd_Data_A, Rd_Data_B, Stall, Busy_Vec
  );

endinterface : regfile_2r1w_sb_if

// File: rtl/regfile_busy_sb.sv
// Busy-bit scoreboard for in-flight load destinations; generates Stall.
module regfile_busy_sb
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            busy_set_i,
  input  reg_addr_t       busy_addr_i,
  input  logic            wr_en_i,
  input  reg_addr_t       wr_addr_i,
  input  reg_addr_t       rd_addr_a_i,
  input  logic            rd_use_a_i,
  input  reg_addr_t       rd_addr_b_i,
  input  logic            rd_use_b_i,
  output logic            stall_o,
  output logic [NREG-1:0] busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            hit_a;
  logic            hit_b;

  // Next busy state: a new load's set beats a same-edge writeback clear; x0 never busy
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (busy_set_i && (busy_addr_i == reg_addr_t'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_en_i && (wr_addr_i == reg_addr_t'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy bits register, cleared asynchronously with the pipeline flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A used operand stalls on a busy source unless its writeback is arriving right now
  always_comb begin
    hit_a = rd_use_a_i && (rd_addr_a_i != ZERO_REG) && busy_q[rd_addr_a_i]
            && !(wr_en_i && (wr_addr_i == rd_addr_a_i));
    hit_b = rd_use_b_i && (rd_addr_b_i != ZERO_REG) && busy_q[rd_addr_b_i]
            && !(wr_en_i && (wr_addr_i == rd_addr_b_i));
    stall_o    = hit_a || hit_b;
    busy_vec_o = busy_q;
  end

endmodule : regfile_busy_sb

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write integer register file with write-to-read bypass and load scoreboard.
module regfile_2r1w_sb
  import riscv_pkg::*;
(
  input logic              Clock,
  input logic              Reset_n,
  regfile_2r1w_sb_if.slave rf
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] rd_a;
  logic [XLEN-1:0] rd_b;

  // Architectural storage; x0 is never written so it stays at its reset value of zero
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf.Wr_En && (rf.Wr_Addr != ZERO_REG)) begin
      regs_q[rf.Wr_Addr] <= rf.Wr_Data;
    end
  end

  // Read muxes: x0 reads zero, same-cycle writeback bypasses, reads forced to zero in reset
  always_comb begin
    rd_a = regs_q[rf.Rd_Addr_A];
    if (!Reset_n || (rf.Rd_Addr_A == ZERO_REG)) begin
      rd_a = '0;
    end else if (rf.Wr_En && (rf.Wr_Addr == rf.Rd_Addr_A)) begin
      rd_a = rf.Wr_Data;
    end

    rd_b = regs_q[rf.Rd_Addr_B];
    if (!Reset_n || (rf.Rd_Addr_B == ZERO_REG)) begin
      rd_b = '0;
    end else if (rf.Wr_En && (rf.Wr_Addr == rf.Rd_Addr_B)) begin
      rd_b = rf.Wr_Data;
    end
  end

  assign rf.Rd_Data_A = rd_a;
  assign rf.Rd_Data_B = rd_b;

  regfile_busy_sb u_busy (
    .clk_i       (Clock),
    .rst_ni      (Reset_n),
    .busy_set_i  (rf.Busy_Set),
    .busy_addr_i (rf.Busy_Addr),
    .wr_en_i     (rf.Wr_En),
    .wr_addr_i   (rf.Wr_Addr),
    .rd_addr_a_i (rf.Rd_Addr_A),
    .rd_use_a_i  (rf.Rd_Use_A),
    .rd_addr_b_i (rf.Rd_Addr_B),
    .rd_use_b_i  (rf.Rd_Use_B),
    .stall_o     (rf.Stall),
    .busy_vec_o  (rf.Busy_Vec)
  );

endmodule : regfile_2r1w_sb

// File: tb/tb_regfile_2r1w_sb.sv
// Directed self-checking bench for regfile_2r1w_sb.
module tb_regfile_2r1w_sb;

  logic Clock;
  logic Reset_n;
  int   n_cmp;
  int   n_err;

  regfile_2r1w_sb_if bus ();

  regfile_2r1w_sb dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .rf      (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.Rd_Addr_A = '0;
    bus.Rd_Use_A  = 1'b0;
    bus.Rd_Addr_B = '0;
    bus.Rd_Use_B  = 1'b0;
    bus.Wr_En     = 1'b0;
    bus.Wr_Addr   = '0;
    bus.Wr_Data   = '0;
    bus.Busy_Set  = 1'b0;
    bus.Busy_Addr = '0;
  endtask

  task automatic test_reset();
    idle();
    Reset_n = 1'b0;
    tick();
    tick();
    #2 Reset_n = 1'b1;
    tick();
    bus.Rd_Use_A = 1'b1;
    bus.Rd_Use_B = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.Rd_Addr_A = 5'(i);
      bus.Rd_Addr_B = 5'(31 - i);
      #1;
      n_cmp++;
      if (bus.Rd_Data_A !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rdA[%0d] got %h exp %h", i, bus.Rd_Data_A, 32'h0);
      end
      n_cmp++;
      if (bus.Rd_Data_B !== 32'h0) begin
        n_err++;
        $display("FAIL reset_rdB[%0d] got %h exp %h", 31 - i, bus.Rd_Data_B, 32'h0);
      end
      n_cmp++;
      if (bus.Stall !== 1'b0) begin
        n_err++;
        $display("FAIL reset_stall[%0d] got %b exp 0", i, bus.Stall);
      end
    end
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0) begin
      n_err++;
      $display("FAIL reset_busyvec got %h exp %h", bus.Busy_Vec, 32'h0);
    end
    idle();
  endtask

  task automatic test_write_read();
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = 5'd5;
    bus.Wr_Data = 32'hDEADBEEF;
    tick();
    idle();
    bus.Rd_Addr_A = 5'd5;
    bus.Rd_Addr_B = 5'd5;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_x5_rdA got %h exp %h", bus.Rd_Data_A, 32'hDEADBEEF);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wr_x5_rdB got %h exp %h", bus.Rd_Data_B, 32'hDEADBEEF);
    end
    // Write to x0: neither bypassed nor stored
    bus.Wr_En     = 1'b1;
    bus.Wr_Addr   = 5'd0;
    bus.Wr_Data   = 32'h00001234;
    bus.Rd_Addr_A = 5'd0;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'h0) begin
      n_err++;
      $display("FAIL x0_no_bypass got %h exp %h", bus.Rd_Data_A, 32'h0);
    end
    tick();
    idle();
    bus.Rd_Addr_A = 5'd0;
    bus.Rd_Addr_B = 5'd5;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'h0) begin
      n_err++;
      $display("FAIL x0_stays_zero got %h exp %h", bus.Rd_Data_A, 32'h0);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL x5_after_x0_write got %h exp %h", bus.Rd_Data_B, 32'hDEADBEEF);
    end
    idle();
  endtask

  task automatic test_bypass();
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = 5'd7;
    bus.Wr_Data = 32'h11111111;
    tick();
    idle();
    bus.Wr_En     = 1'b1;
    bus.Wr_Addr   = 5'd7;
    bus.Wr_Data   = 32'hA5A5A5A5;
    bus.Rd_Addr_A = 5'd7;
    bus.Rd_Addr_B = 5'd5;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL bypass_rdA got %h exp %h", bus.Rd_Data_A, 32'hA5A5A5A5);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL bypass_other_port got %h exp %h", bus.Rd_Data_B, 32'hDEADBEEF);
    end
    // Old value still stored until the edge: visible once write strobe drops
    bus.Wr_En = 1'b0;
    bus.Rd_Addr_B = 5'd7;
    #1;
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h11111111) begin
      n_err++;
      $display("FAIL old_x7_no_wr got %h exp %h", bus.Rd_Data_B, 32'h11111111);
    end
    bus.Wr_En = 1'b1;
    tick();
    idle();
    bus.Rd_Addr_A = 5'd7;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL x7_stored got %h exp %h", bus.Rd_Data_A, 32'hA5A5A5A5);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    bus.Busy_Set  = 1'b1;
    bus.Busy_Addr = 5'd9;
    tick();
    idle();
    bus.Rd_Use_B  = 1'b1;
    bus.Rd_Addr_B = 5'd9;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b1) begin
      n_err++;
      $display("FAIL busy_x9_stall got %b exp 1", bus.Stall);
    end
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL busy_x9_vec got %h exp %h", bus.Busy_Vec, 32'h0000_0200);
    end
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = 5'd9;
    bus.Wr_Data = 32'h00000042;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL wb_x9_stall got %b exp 0", bus.Stall);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h00000042) begin
      n_err++;
      $display("FAIL wb_x9_bypass got %h exp %h", bus.Rd_Data_B, 32'h00000042);
    end
    tick();
    idle();
    bus.Rd_Use_B  = 1'b1;
    bus.Rd_Addr_B = 5'd9;
    #1;
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0) begin
      n_err++;
      $display("FAIL x9_cleared_vec got %h exp %h", bus.Busy_Vec, 32'h0);
    end
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL x9_cleared_stall got %b exp 0", bus.Stall);
    end
    idle();
  endtask

  task automatic test_set_clear_priority();
    bus.Busy_Set  = 1'b1;
    bus.Busy_Addr = 5'd3;
    bus.Wr_En     = 1'b1;
    bus.Wr_Addr   = 5'd3;
    bus.Wr_Data   = 32'h00000033;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL set_wins_vec got %h exp %h", bus.Busy_Vec, 32'h0000_0008);
    end
    bus.Busy_Set  = 1'b1;
    bus.Busy_Addr = 5'd0;
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL busy_x0_ignored got %h exp %h", bus.Busy_Vec, 32'h0000_0008);
    end
    bus.Rd_Addr_A = 5'd3;
    bus.Rd_Use_A  = 1'b0;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL unused_busy_stall got %b exp 0", bus.Stall);
    end
    bus.Rd_Use_A = 1'b1;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b1) begin
      n_err++;
      $display("FAIL used_busy_stall got %b exp 1", bus.Stall);
    end
    bus.Rd_Addr_A = 5'd0;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL x0_use_stall got %b exp 0", bus.Stall);
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.Busy_Set  = 1'b1;
    bus.Busy_Addr = 5'd4;
    bus.Wr_En     = 1'b1;
    bus.Wr_Addr   = 5'd6;
    bus.Wr_Data   = 32'h00000077;
    tick();
    idle();
    bus.Rd_Addr_A = 5'd4;
    bus.Rd_Use_A  = 1'b1;
    bus.Rd_Addr_B = 5'd6;
    #1;
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0000_0018) begin
      n_err++;
      $display("FAIL pre_reset_vec got %h exp %h", bus.Busy_Vec, 32'h0000_0018);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h00000077) begin
      n_err++;
      $display("FAIL pre_reset_x6 got %h exp %h", bus.Rd_Data_B, 32'h00000077);
    end
    // Mid-cycle reset pulse, no clock edge involved
    #1 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_vec got %h exp %h", bus.Busy_Vec, 32'h0);
    end
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_stall got %b exp 0", bus.Stall);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst_x6 got %h exp %h", bus.Rd_Data_B, 32'h0);
    end
    // A write strobe during reset must neither bypass nor store
    bus.Wr_En     = 1'b1;
    bus.Wr_Addr   = 5'd6;
    bus.Wr_Data   = 32'hCAFEF00D;
    bus.Busy_Set  = 1'b1;
    bus.Busy_Addr = 5'd6;
    #1;
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h0) begin
      n_err++;
      $display("FAIL rst_no_bypass got %h exp %h", bus.Rd_Data_B, 32'h0);
    end
    tick();
    idle();
    #2 Reset_n = 1'b1;
    bus.Rd_Addr_A = 5'd5;
    bus.Rd_Addr_B = 5'd6;
    #1;
    n_cmp++;
    if (bus.Rd_Data_A !== 32'h0) begin
      n_err++;
      $display("FAIL post_rst_x5 got %h exp %h", bus.Rd_Data_A, 32'h0);
    end
    n_cmp++;
    if (bus.Rd_Data_B !== 32'h0) begin
      n_err++;
      $display("FAIL post_rst_x6 got %h exp %h", bus.Rd_Data_B, 32'h0);
    end
    n_cmp++;
    if (bus.Busy_Vec !== 32'h0) begin
      n_err++;
      $display("FAIL post_rst_vec got %h exp %h", bus.Busy_Vec, 32'h0);
    end
    idle();
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    Reset_n = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_clear_priority();
    test_async_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_regfile_2r1w_sb
